commit_trace_encoder: RTL and testbench

COMMIT_TRACE_ENCODER -- requirements
Module: commit_trace_encoder

---
 rtl/commit_trace_encoder.sv | 214 +++++++++++++++++++++
 tb/tb_commit_trace_encoder.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/commit_trace_encoder.sv
// Commit trace encoder: classifies each retiring instruction into a trace record and queues it in a first-word-fall-through FIFO.
// Optional feature: define TRACE_NOP_EN to also emit NOP/branch (type 0) records.
module commit_trace_encoder #(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [15:0]                pc,
    input  logic                       reg_write,
    input  logic [3:0]                 write_reg,
    input  logic [15:0]                write_data,
    input  logic                       mem_read,
    input  logic                       mem_write,
    input  logic [15:0]                mem_addr,
    input  logic [15:0]                mem_data,
    input  logic                       hlt,
    input  logic                       rec_ready,
    output logic                       rec_valid,
    output logic [1:0]                 rec_type,
    output logic                       rec_load,
    output logic [15:0]                rec_inum,
    output logic [15:0]                rec_pc,
    output logic [3:0]                 rec_reg,
    output logic [15:0]                rec_a,
    output logic [15:0]                rec_b,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow,
    output logic                       done
);
    localparam int LW = $clog2(DEPTH) + 1;
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
    localparam logic [LW-1:0] LVL_ONE  = {{(LW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {ST_RUN = 2'd0, ST_DRAIN = 2'd1, ST_DONE = 2'd2} state_t;

    typedef struct packed {
        logic [1:0]  rtype;
        logic        load;
        logic [15:0] inum;
        logic [15:0] pc;
        logic [3:0]  rg;
        logic [15:0] a;
        logic [15:0] b;
    } rec_t;

    state_t          state_r, state_nxt_s;
    rec_t            mem_r     [DEPTH];
    rec_t            mem_nxt_s [DEPTH];
    logic [LW-1:0]   count_r;
    logic [15:0]     inum_r;
    logic            overflow_r;
    logic            hold_vld_r;
    rec_t            hold_rec_r;

    rec_t            cand_s, push_rec_s;
    logic            cand_vld_s, cand_halt_s;
    logic            full_s, pop_s, room_s;
    logic            push_s, hold_set_s, hold_clr_s, drop_s, inc_s;
    logic [LW-1:0]   wr_idx_s;

    // Classify the retiring instruction into a candidate record.
    always_comb begin
        cand_s      = '0;
        cand_s.inum = inum_r;
        cand_s.pc   = pc;
        cand_vld_s  = 1'b0;
        cand_halt_s = 1'b0;
        if (reg_write) begin
            cand_s.rtype = 2'd1;
            cand_s.load  = mem_read;
            cand_s.rg    = write_reg;
            cand_s.a     = write_data;
            cand_s.b     = mem_read ? mem_addr : 16'h0000;
            cand_vld_s   = 1'b1;
        end else if (hlt) begin
            cand_s.rtype = 2'd3;
            cand_vld_s   = 1'b1;
            cand_halt_s  = 1'b1;
        end else if (mem_write) begin
            cand_s.rtype = 2'd2;
            cand_s.a     = mem_addr;
            cand_s.b     = mem_data;
            cand_vld_s   = 1'b1;
        end else begin
`ifdef TRACE_NOP_EN
            cand_s.rtype = 2'd0;
            cand_vld_s   = 1'b1;
`else
            cand_vld_s   = 1'b0;
`endif
        end
    end

    assign full_s = (count_r == LVL_FULL);
    assign pop_s  = (count_r != {LW{1'b0}}) && rec_ready;
    assign room_s = !full_s || pop_s;

    // Push/hold/drop decision and state transitions.
    always_comb begin
        push_s      = 1'b0;
        push_rec_s  = cand_s;
        hold_set_s  = 1'b0;
        hold_clr_s  = 1'b0;
        drop_s      = 1'b0;
        inc_s       = 1'b0;
        state_nxt_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (cand_vld_s) begin
                    if (room_s) begin
                        push_s = 1'b1;
                        inc_s  = 1'b1;
                    end else if (cand_halt_s) begin
                        hold_set_s = 1'b1;
                        inc_s      = 1'b1;
                    end else begin
                        drop_s = 1'b1;
                    end
                    state_nxt_s = cand_halt_s ? ST_DRAIN : ST_RUN;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (hold_vld_r && room_s) begin
                    push_s     = 1'b1;
                    push_rec_s = hold_rec_r;
                    hold_clr_s = 1'b1;
                end else begin
                    push_s = 1'b0;
                end
                // HALT is always the youngest record, so popping the last entry with nothing held retires it.
                if (pop_s && (count_r == LVL_ONE) && !hold_vld_r) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_DONE;
            end
            default: begin
                state_nxt_s = ST_RUN;
            end
        endcase
    end

    assign wr_idx_s = count_r - {{(LW-1){1'b0}}, pop_s};

    // Shift-register FIFO: entry 0 is always the head, so outputs come straight from flops.
    always_comb begin
        for (int i = 0; i < DEPTH - 1; i++) begin
            mem_nxt_s[i] = pop_s ? mem_r[i+1] : mem_r[i];
        end
        mem_nxt_s[DEPTH-1] = pop_s ? '0 : mem_r[DEPTH-1];
        for (int i = 0; i < DEPTH; i++) begin
            if (push_s && (LW'(i) == wr_idx_s)) begin
                mem_nxt_s[i] = push_rec_s;
            end else begin
                mem_nxt_s[i] = mem_nxt_s[i];
            end
        end
    end

    // State, FIFO storage, counters and sticky flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= ST_RUN;
            count_r    <= '0;
            inum_r     <= 16'h0000;
            overflow_r <= 1'b0;
            hold_vld_r <= 1'b0;
            hold_rec_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            state_r <= state_nxt_s;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= mem_nxt_s[i];
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + LVL_ONE;
                2'b01:   count_r <= count_r - LVL_ONE;
                default: count_r <= count_r;
            endcase
            if (inc_s) begin
                inum_r <= inum_r + 16'h0001;
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
            if (hold_set_s) begin
                hold_vld_r <= 1'b1;
                hold_rec_r <= cand_s;
            end else if (hold_clr_s) begin
                hold_vld_r <= 1'b0;
            end
        end
    end

    assign rec_valid = (count_r != {LW{1'b0}});
    assign rec_type  = mem_r[0].rtype;
    assign rec_load  = mem_r[0].load;
    assign rec_inum  = mem_r[0].inum;
    assign rec_pc    = mem_r[0].pc;
    assign rec_reg   = mem_r[0].rg;
    assign rec_a     = mem_r[0].a;
    assign rec_b     = mem_r[0].b;
    assign level     = count_r;
    assign overflow  = overflow_r;
    assign done      = (state_r == ST_DONE);

endmodule

// File: tb/tb_commit_trace_encoder.sv
// Self-checking bench for commit_trace_encoder: directed vector table, corner-case sequences and a queue-based reference model.
module tb_commit_trace_encoder;
    localparam int DEPTH = 8;
    localparam int LW    = $clog2(DEPTH) + 1;
`ifdef TRACE_NOP_EN
    localparam int NOPS = 1;
`else
    localparam int NOPS = 0;
`endif

    typedef struct packed {
        logic [1:0]  t;
        logic        ld;
        logic [15:0] inum;
        logic [15:0] pc;
        logic [3:0]  rg;
        logic [15:0] a;
        logic [15:0] b;
    } mrec_t;

    typedef struct {
        logic          rst_n;
        logic [15:0]   pc;
        logic          rw;
        logic [3:0]    wr;
        logic [15:0]   wd;
        logic          mr;
        logic          mw;
        logic [15:0]   ma;
        logic [15:0]   md;
        logic          hlt;
        logic          rdy;
        logic          e_valid;
        logic          chk_rec;
        mrec_t         e_rec;
        logic [LW-1:0] e_level;
        logic          e_done;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n, reg_write, mem_read, mem_write, hlt, rec_ready;
    logic [15:0] pc, write_data, mem_addr, mem_data;
    logic [3:0]  write_reg;
    logic        rec_valid, rec_load, overflow, done;
    logic [1:0]  rec_type;
    logic [15:0] rec_inum, rec_pc, rec_a, rec_b;
    logic [3:0]  rec_reg;
    logic [LW-1:0] level;

    int n_checks = 0;
    int n_pass   = 0;

    mrec_t mq[$];
    logic [15:0] m_inum;
    bit    m_ovf, m_halted, m_done, m_hold;
    mrec_t m_hold_rec;

    always #5 clk = ~clk;

    commit_trace_encoder #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .pc(pc), .reg_write(reg_write), .write_reg(write_reg),
        .write_data(write_data), .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_data(mem_data), .hlt(hlt), .rec_ready(rec_ready), .rec_valid(rec_valid),
        .rec_type(rec_type), .rec_load(rec_load), .rec_inum(rec_inum), .rec_pc(rec_pc),
        .rec_reg(rec_reg), .rec_a(rec_a), .rec_b(rec_b), .level(level), .overflow(overflow),
        .done(done)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic mrec_t mk(input int t, input int ld, input int inum, input int p,
                                 input int rg, input int a, input int b);
        mrec_t r;
        r.t = 2'(t); r.ld = 1'(ld); r.inum = 16'(inum); r.pc = 16'(p);
        r.rg = 4'(rg); r.a = 16'(a); r.b = 16'(b);
        return r;
    endfunction

    // Spec-level classification of the current inputs; returns 1 when a record is produced.
    function automatic bit m_classify(output mrec_t r, output bit is_halt);
        r = '0; is_halt = 1'b0; r.pc = pc; r.inum = m_inum;
        if (reg_write) begin
            r.t = 2'd1; r.ld = mem_read; r.rg = write_reg; r.a = write_data;
            r.b = mem_read ? mem_addr : 16'h0000;
            return 1'b1;
        end
        if (hlt) begin
            r.t = 2'd3; is_halt = 1'b1;
            return 1'b1;
        end
        if (mem_write) begin
            r.t = 2'd2; r.a = mem_addr; r.b = mem_data;
            return 1'b1;
        end
        return (NOPS != 0);
    endfunction

    task automatic model_update();
        mrec_t c;
        bit ch, cv;
        if (!rst_n) begin
            mq.delete(); m_inum = 16'h0000; m_ovf = 0; m_halted = 0; m_done = 0; m_hold = 0;
            return;
        end
        if (mq.size() > 0 && rec_ready) begin
            if (mq[0].t == 2'd3) m_done = 1;
            mq.delete(0);
        end
        if (!m_halted) begin
            cv = m_classify(c, ch);
            if (cv) begin
                if (mq.size() < DEPTH) begin
                    mq.push_back(c); m_inum = m_inum + 16'h0001;
                end else if (ch) begin
                    m_hold = 1; m_hold_rec = c; m_inum = m_inum + 16'h0001;
                end else begin
                    m_ovf = 1;
                end
                if (ch) m_halted = 1;
            end
        end else if (m_hold && mq.size() < DEPTH) begin
            mq.push_back(m_hold_rec); m_hold = 0;
        end
    endtask

    task automatic model_compare();
        check("m_valid", rec_valid, mq.size() > 0);
        check("m_level", level, mq.size());
        check("m_overflow", overflow, m_ovf);
        check("m_done", done, m_done);
        if (mq.size() > 0)
            check("m_head", {rec_type, rec_load, rec_inum, rec_pc, rec_reg, rec_a, rec_b}, mq[0]);
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        model_compare();
    endtask

    task automatic set_idle();
        pc = 16'h0000; reg_write = 0; write_reg = 4'h0; write_data = 16'h0000; mem_read = 0;
        mem_write = 0; mem_addr = 16'h0000; mem_data = 16'h0000; hlt = 0;
    endtask

    task automatic set_reg(input int p, input int r, input int d);
        set_idle(); pc = 16'(p); reg_write = 1; write_reg = 4'(r); write_data = 16'(d);
    endtask

    task automatic do_reset();
        set_idle(); rec_ready = 0; rst_n = 0;
        step();
        rst_n = 1;
    endtask

    vec_t vt[11];

    initial begin
        int last_inum, npop, last_type;
        set_idle(); rec_ready = 0; rst_n = 0;

        // Directed vector table (expected values hand-derived).
        foreach (vt[i]) begin
            vt[i] = '{rst_n: 1'b1, pc: 16'h0, rw: 1'b0, wr: 4'h0, wd: 16'h0, mr: 1'b0, mw: 1'b0,
                      ma: 16'h0, md: 16'h0, hlt: 1'b0, rdy: 1'b1, e_valid: 1'b0, chk_rec: 1'b0,
                      e_rec: '0, e_level: '0, e_done: 1'b0};
        end
        vt[0].rst_n = 0; vt[0].rdy = 0; vt[0].chk_rec = 1;
        vt[1].pc = 16'h0002; vt[1].rw = 1; vt[1].wr = 4'h3; vt[1].wd = 16'h1234;
        vt[1].e_valid = 1; vt[1].chk_rec = 1; vt[1].e_level = 1; vt[1].e_rec = mk(1, 0, 0, 2, 3, 'h1234, 0);
        vt[2].rst_n = 0; vt[2].chk_rec = 1;
        vt[3].pc = 16'h0004; vt[3].rw = 1; vt[3].wr = 4'h5; vt[3].wd = 16'hBEEF; vt[3].mr = 1; vt[3].ma = 16'h0040;
        vt[3].e_valid = 1; vt[3].chk_rec = 1; vt[3].e_level = 1; vt[3].e_rec = mk(1, 1, 0, 4, 5, 'hBEEF, 'h0040);
        vt[4].pc = 16'h0006; vt[4].mw = 1; vt[4].ma = 16'h0042; vt[4].md = 16'h00AA;
        vt[4].e_valid = 1; vt[4].chk_rec = 1; vt[4].e_level = 1; vt[4].e_rec = mk(2, 0, 1, 6, 0, 'h0042, 'h00AA);
        vt[5].pc = 16'h0008; vt[5].mr = 1;
        vt[5].e_valid = 1'(NOPS); vt[5].chk_rec = 1'(NOPS); vt[5].e_level = LW'(NOPS); vt[5].e_rec = mk(0, 0, 2, 8, 0, 0, 0);
        vt[6].pc = 16'h000A; vt[6].rw = 1; vt[6].wr = 4'h7; vt[6].wd = 16'h5555;
        vt[6].e_valid = 1; vt[6].chk_rec = 1; vt[6].e_level = 1; vt[6].e_rec = mk(1, 0, 2 + NOPS, 'hA, 7, 'h5555, 0);
        vt[7].pc = 16'h000C; vt[7].mw = 1; vt[7].mr = 1; vt[7].ma = 16'h0100; vt[7].md = 16'h0077;
        vt[7].e_valid = 1; vt[7].chk_rec = 1; vt[7].e_level = 1; vt[7].e_rec = mk(2, 0, 3 + NOPS, 'hC, 0, 'h0100, 'h0077);
        vt[8].pc = 16'h000E; vt[8].rw = 1; vt[8].hlt = 1; vt[8].wr = 4'h9; vt[8].wd = 16'h9999;
        vt[8].e_valid = 1; vt[8].chk_rec = 1; vt[8].e_level = 1; vt[8].e_rec = mk(1, 0, 4 + NOPS, 'hE, 9, 'h9999, 0);
        vt[9].pc = 16'h0010; vt[9].hlt = 1; vt[9].mw = 1; vt[9].ma = 16'h0001; vt[9].md = 16'h0002;
        vt[9].e_valid = 1; vt[9].chk_rec = 1; vt[9].e_level = 1; vt[9].e_rec = mk(3, 0, 5 + NOPS, 'h10, 0, 0, 0);
        vt[10].pc = 16'h0012; vt[10].rw = 1; vt[10].wd = 16'h4321; vt[10].e_done = 1;

        for (int i = 0; i < 11; i++) begin
            rst_n = vt[i].rst_n; pc = vt[i].pc; reg_write = vt[i].rw; write_reg = vt[i].wr;
            write_data = vt[i].wd; mem_read = vt[i].mr; mem_write = vt[i].mw; mem_addr = vt[i].ma;
            mem_data = vt[i].md; hlt = vt[i].hlt; rec_ready = vt[i].rdy;
            step();
            check($sformatf("tbl%0d_valid", i), rec_valid, vt[i].e_valid);
            check($sformatf("tbl%0d_level", i), level, vt[i].e_level);
            check($sformatf("tbl%0d_done", i), done, vt[i].e_done);
            if (vt[i].chk_rec)
                check($sformatf("tbl%0d_rec", i), {rec_type, rec_load, rec_inum, rec_pc, rec_reg, rec_a, rec_b}, vt[i].e_rec);
        end

        // Overflow: DEPTH+2 writes with the consumer stalled.
        do_reset();
        for (int i = 0; i < DEPTH + 2; i++) begin
            set_reg(i * 2, i, i);
            step();
        end
        check("ovf_level", level, DEPTH);
        check("ovf_flag", overflow, 1);
        check("ovf_head", rec_inum, 0);
        set_idle(); rec_ready = 1; last_inum = -1;
        for (int k = 0; k < DEPTH + 4; k++) begin
            if (rec_valid) last_inum = int'(rec_inum);
            step();
        end
        check("ovf_last_inum", last_inum, DEPTH - 1);

        // Full with simultaneous pop and push.
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            set_reg(i, 1, i + 100);
            step();
        end
        rec_ready = 1; set_reg('h50, 2, 'h77);
        step();
        check("fullpp_level", level, DEPTH);
        check("fullpp_ovf", overflow, 0);
        check("fullpp_head", rec_inum, 1);

        // HALT while full and stalled: held, then emitted last.
        rec_ready = 0; set_idle(); hlt = 1;
        step();
        check("halt_held_level", level, DEPTH);
        check("halt_held_ovf", overflow, 0);
        check("halt_held_done", done, 0);
        set_reg('h60, 4, 'hDEAD); rec_ready = 1; npop = 0; last_type = -1; last_inum = -1;
        for (int k = 0; k < 3 * DEPTH && !done; k++) begin
            if (rec_valid) begin
                npop++; last_type = int'(rec_type); last_inum = int'(rec_inum);
            end
            step();
        end
        check("halt_done", done, 1);
        check("halt_npop", npop, DEPTH + 1);
        check("halt_last_type", last_type, 3);
        check("halt_last_inum", last_inum, DEPTH + 1);
        for (int k = 0; k < 3; k++) begin
            set_reg(k, 5, k); mem_write = 1;
            step();
            check("done_hold", {done, rec_valid, level}, {1'b1, 1'b0, {LW{1'b0}}});
        end

        // Reset in the middle of a drain.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_reg(i, 6, i);
            step();
        end
        set_idle(); hlt = 1;
        step();
        rst_n = 0;
        step();
        check("middrain_state", {done, rec_valid, level, overflow}, '0);
        rst_n = 1; rec_ready = 1; set_reg('h70, 8, 'h1111);
        step();
        check("middrain_inum", rec_inum, 0);

        // Randomized traffic against the reference model.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            rst_n      = m_done ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 299) != 0);
            pc         = 16'($urandom);
            reg_write  = ($urandom_range(0, 2) == 0);
            write_reg  = 4'($urandom);
            write_data = 16'($urandom);
            mem_read   = 1'($urandom);
            mem_write  = ($urandom_range(0, 2) == 0);
            mem_addr   = 16'($urandom);
            mem_data   = 16'($urandom);
            hlt        = ($urandom_range(0, 79) == 0);
            rec_ready  = ((c / 100) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
